hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16; number of architectural registers tracked.
REQ-002 SHALL have parameter ISSUE_W, default 4; instruction slots per cycle, and also writeback ports per cycle.
REQ-003 SHALL have parameter OP_W, default 4; opcode width.
REQ-004 SHALL have parameter IN_ORDER, default 1; 1 = in-order grant, 0 = out-of-order grant within a group.
REQ-005 SHALL derive localparam RA_W = clog2(NUM_REGS); register-index width.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush_en  in  1  flush request this cycle.
REQ-009 flush_reg  in  NUM_REGS  mask of busy bits to clear on flush.
REQ-010 ins_in_vld  in  ISSUE_W  per-slot valid; slot 0 is oldest.
REQ-011 ins_in_des / ins_in_source1 / ins_in_source2  in  ISSUE_W*RA_W each  per-slot destination and source indices.
REQ-012 op  in  ISSUE_W*OP_W  per-slot opcode; value 0 means no destination write.
REQ-013 ins_back_vld  in  ISSUE_W; ins_back_des  in  ISSUE_W*RA_W  writeback ports.
REQ-014 ins_out  out  ISSUE_W  per-slot grant.
REQ-015 ins_swap  out  ISSUE_W  slot granted ahead of an older, valid, ungranted slot.
REQ-016 busy  out  NUM_REGS  current busy table.
REQ-017 stall_cnt, issue_cnt  out  32 each  statistics counters (see Configuration).

Function
REQ-018 Busy table SHALL be NUM_REGS flops; busy[r]=1 means r has an issued, un-written-back producer.
REQ-019 ins_out SHALL be combinational from the busy table and the current-cycle inputs; grants take effect in the same cycle.
REQ-020 A source or destination SHALL count as ready if busy is 0, or if any ins_back_vld port writes it back this cycle (bypass).
REQ-021 Slot i SHALL be grantable only if: valid; both sources ready (RAW); destination ready when op!=0 (WAW).
REQ-022 Slot i SHALL also be blocked by any older valid slot j<i in the group that: writes a source of i (RAW), writes i's destination (WAW), or reads i's destination (WAR).
REQ-023 With IN_ORDER=1, slot i SHALL be granted only if all older valid slots are granted; ins_swap SHALL be all 0.
REQ-024 With IN_ORDER=0, a grantable slot SHALL be granted regardless of older stalls; ins_swap[i] SHALL be 1 if granted and any older valid slot is not granted.
REQ-025 With flush_en=1, ins_out and ins_swap SHALL be all 0 in that cycle.
REQ-026 Next-state order: busy &= ~flush_mask; then clear writeback destinations; then set destinations of granted slots with op!=0.
REQ-027 flush_mask SHALL equal flush_reg when flush_en=1, else 0.
REQ-028 When a writeback and a grant target the same register in one cycle, the grant (set) SHALL win.
REQ-029 A writeback to a non-busy register SHALL be ignored; duplicate writebacks to the same register SHALL act as one.
REQ-030 ins_in_vld=0 slots SHALL never be granted and SHALL not block younger slots.

Reset
REQ-031 While rst=1: busy SHALL be all 0; stall_cnt and issue_cnt SHALL be 0; ins_out and ins_swap SHALL be all 0.
REQ-032 Reset asserted mid-operation SHALL clear state immediately, without waiting for a clock edge; grants SHALL resume on the first edge after release.

Configuration
REQ-033 Macro HAZARD_SCOREBOARD_STATS_EN defined: at each edge, stall_cnt SHALL add 1 if any valid slot is ungranted; issue_cnt SHALL add popcount(ins_out); both SHALL saturate at 2^32-1.
REQ-034 Macro undefined: the counters SHALL not be built, and stall_cnt and issue_cnt SHALL be tied to 0.

Verification
REQ-035 Reset, then slot0 des=3 op=1 src=1,2 -> ins_out=0001; the next cycle busy[3]=1.
REQ-036 busy[3]=1, slot0 src1=3, with ins_back_vld[0]=1 des=3 in the same cycle -> ins_out[0]=1 (bypass); busy[3] ends 0 unless slot0 writes 3.
REQ-037 IN_ORDER=0, busy[5]=1, slot0 src1=5, slot1 des=6 src=7,8 -> ins_out=0010, ins_swap=0010; with IN_ORDER=1 -> ins_out=0000.
REQ-038 Slot0 des=4, slot1 src2=4, all regs free -> ins_out=0001 (intra-group RAW).
REQ-039 busy=0x00F0, flush_en=1, flush_reg=0x0030, all four slots valid -> ins_out=0000; the next cycle busy=0x00C0.
REQ-040 With STATS_EN and stall_cnt forced near 2^32-1, a stalled cycle -> stall_cnt holds at 0xFFFFFFFF; assert rst mid-run -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Multi-issue register hazard scoreboard: busy table, grant logic, stats.
// Define HAZARD_SCOREBOARD_STATS_EN to build the stall/issue counters.
module hazard_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ISSUE_W  = 4,
  parameter int OP_W     = 4,
  parameter int IN_ORDER = 1,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_en,
  input  logic [NUM_REGS-1:0]     flush_reg,
  input  logic [ISSUE_W-1:0]      ins_in_vld,
  input  logic [ISSUE_W*RA_W-1:0] ins_in_des,
  input  logic [ISSUE_W*RA_W-1:0] ins_in_source1,
  input  logic [ISSUE_W*RA_W-1:0] ins_in_source2,
  input  logic [ISSUE_W*OP_W-1:0] op,
  input  logic [ISSUE_W-1:0]      ins_back_vld,
  input  logic [ISSUE_W*RA_W-1:0] ins_back_des,
  output logic [ISSUE_W-1:0]      ins_out,
  output logic [ISSUE_W-1:0]      ins_swap,
  output logic [NUM_REGS-1:0]     busy,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             issue_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_n;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] rdy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] flush_mask;

  logic [RA_W-1:0] d  [ISSUE_W];
  logic [RA_W-1:0] s1 [ISSUE_W];
  logic [RA_W-1:0] s2 [ISSUE_W];

  logic [ISSUE_W-1:0] wr;
  logic [ISSUE_W-1:0] cand;
  logic [ISSUE_W-1:0] grant;
  logic [ISSUE_W-1:0] swap;

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      d[i]  = ins_in_des[i*RA_W +: RA_W];
      s1[i] = ins_in_source1[i*RA_W +: RA_W];
      s2[i] = ins_in_source2[i*RA_W +: RA_W];
      wr[i] = ins_in_vld[i] && (op[i*OP_W +: OP_W] != '0);
    end
  end

  // duplicate writebacks collapse into one hit per register
  always_comb begin
    wb_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (ins_back_vld[k] &&
            ins_back_des[k*RA_W +: RA_W] == RA_W'(r))
          wb_hit[r] = 1'b1;
      end
    end
  end

  assign rdy = ~busy_q | wb_hit;

  always_comb begin
    cand = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      cand[i] = ins_in_vld[i] && rdy[s1[i]] && rdy[s2[i]] &&
                (!wr[i] || rdy[d[i]]);
      for (int j = 0; j < ISSUE_W; j++) begin
        if (j < i && ins_in_vld[j]) begin
          if (wr[j] && (d[j] == s1[i] || d[j] == s2[i]))
            cand[i] = 1'b0;
          if (wr[j] && wr[i] && d[j] == d[i])
            cand[i] = 1'b0;
          if (wr[i] && (s1[j] == d[i] || s2[j] == d[i]))
            cand[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic older_ok;
    logic older_stall;
    grant       = '0;
    swap        = '0;
    older_ok    = 1'b1;
    older_stall = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (IN_ORDER != 0) begin
        grant[i] = cand[i] && older_ok;
      end else begin
        grant[i] = cand[i];
        swap[i]  = cand[i] && older_stall;
      end
      older_ok    = older_ok && (!ins_in_vld[i] || grant[i]);
      older_stall = older_stall || (ins_in_vld[i] && !grant[i]);
    end
    if (flush_en || rst) begin
      grant = '0;
      swap  = '0;
    end
  end

  assign ins_out  = grant;
  assign ins_swap = swap;

  always_comb begin
    set_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (grant[i] && wr[i] && d[i] == RA_W'(r))
          set_mask[r] = 1'b1;
      end
    end
  end

  // flush, then writeback clear, then grant set (set wins)
  assign flush_mask = flush_en ? flush_reg : '0;
  assign busy_n = ((busy_q & ~flush_mask) & ~wb_hit) | set_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_n;
  end

  assign busy = busy_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] issue_q;
  logic [31:0] pop;
  logic [32:0] issue_sum;
  logic        stall_any;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ISSUE_W; i++)
      pop = pop + {31'd0, grant[i]};
  end

  assign stall_any = |(ins_in_vld & ~grant);
  assign issue_sum = {1'b0, issue_q} + {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (stall_any && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      issue_q <= issue_sum[32] ? '1 : issue_sum[31:0];
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = issue_q;
`else
  assign stall_cnt = '0;
  assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (in-order and out-of-order instances).
module tb_hazard_scoreboard;
  localparam int NR = 16;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int RA_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush_en;
  logic [NR-1:0] flush_reg;
  logic [IW-1:0] ins_in_vld;
  logic [IW*RA_W-1:0] ins_in_des;
  logic [IW*RA_W-1:0] ins_in_source1;
  logic [IW*RA_W-1:0] ins_in_source2;
  logic [IW*OW-1:0] op;
  logic [IW-1:0] ins_back_vld;
  logic [IW*RA_W-1:0] ins_back_des;

  logic [IW-1:0] ins_out, ins_swap, out_o, swap_o;
  logic [NR-1:0] busy, busy_o;
  logic [31:0] stall_cnt, issue_cnt, stall_o, issue_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.IN_ORDER(1)) dut (
    .clk(clk), .rst(rst), .flush_en(flush_en), .flush_reg(flush_reg),
    .ins_in_vld(ins_in_vld), .ins_in_des(ins_in_des),
    .ins_in_source1(ins_in_source1), .ins_in_source2(ins_in_source2),
    .op(op), .ins_back_vld(ins_back_vld), .ins_back_des(ins_back_des),
    .ins_out(ins_out), .ins_swap(ins_swap), .busy(busy),
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  hazard_scoreboard #(.IN_ORDER(0)) dut_ooo (
    .clk(clk), .rst(rst), .flush_en(flush_en), .flush_reg(flush_reg),
    .ins_in_vld(ins_in_vld), .ins_in_des(ins_in_des),
    .ins_in_source1(ins_in_source1), .ins_in_source2(ins_in_source2),
    .op(op), .ins_back_vld(ins_back_vld), .ins_back_des(ins_back_des),
    .ins_out(out_o), .ins_swap(swap_o), .busy(busy_o),
    .stall_cnt(stall_o), .issue_cnt(issue_o)
  );

  task automatic clr;
    flush_en = 1'b0;
    flush_reg = '0;
    ins_in_vld = '0;
    ins_in_des = '0;
    ins_in_source1 = '0;
    ins_in_source2 = '0;
    op = '0;
    ins_back_vld = '0;
    ins_back_des = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input int d, input int a,
                          input int b, input int o);
    ins_in_vld[i] = 1'b1;
    ins_in_des[i*RA_W +: RA_W] = RA_W'(d);
    ins_in_source1[i*RA_W +: RA_W] = RA_W'(a);
    ins_in_source2[i*RA_W +: RA_W] = RA_W'(b);
    op[i*OW +: OW] = OW'(o);
  endtask

  task automatic set_wb(input int k, input int d);
    ins_back_vld[k] = 1'b1;
    ins_back_des[k*RA_W +: RA_W] = RA_W'(d);
  endtask

  task automatic apply_reset;
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clr();
    rst = 1'b1;
    set_slot(0, 3, 1, 2, 1);
    #2;
    n_chk++;
    if (ins_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 0000", ins_out);
    end
    n_chk++;
    if (busy !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_busy: got %h want 0000", busy);
    end
    n_chk++;
    if (swap_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_swap: got %b want 0000", swap_o);
    end
    n_chk++;
    if (stall_cnt !== 32'd0 || issue_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, issue_cnt);
    end
    apply_reset();
  endtask

  task automatic test_basic;
    apply_reset();
    set_slot(0, 3, 1, 2, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_grant: got %b want 0001", ins_out);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h0008) begin
      n_fail++;
      $display("FAIL basic_busy: got %h want 0008", busy);
    end
  endtask

  task automatic test_bypass;
    apply_reset();
    set_slot(0, 3, 0, 0, 1);
    tick();
    clr();
    set_slot(0, 0, 3, 0, 0);
    #1;
    n_chk++;
    if (ins_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL bypass_nowb: got %b want 0000", ins_out);
    end
    set_wb(0, 3);
    #1;
    n_chk++;
    if (ins_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL bypass_grant: got %b want 0001", ins_out);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h0000) begin
      n_fail++;
      $display("FAIL bypass_clear: got %h want 0000", busy);
    end
    set_slot(0, 3, 0, 0, 1);
    tick();
    clr();
    set_wb(0, 3);
    set_wb(1, 3);
    set_slot(0, 3, 0, 0, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL waw_bypass: got %b want 0001", ins_out);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h0008) begin
      n_fail++;
      $display("FAIL set_wins: got %h want 0008", busy);
    end
    set_wb(0, 3);
    set_wb(1, 3);
    set_wb(2, 5);
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h0000) begin
      n_fail++;
      $display("FAIL dup_wb: got %h want 0000", busy);
    end
  endtask

  task automatic test_swap;
    apply_reset();
    set_slot(0, 5, 0, 0, 1);
    tick();
    clr();
    set_slot(0, 0, 5, 0, 0);
    set_slot(1, 6, 7, 8, 1);
    #1;
    n_chk++;
    if (out_o !== 4'b0010 || swap_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL ooo_swap: got %b/%b want 0010/0010", out_o, swap_o);
    end
    n_chk++;
    if (ins_out !== 4'b0000 || ins_swap !== 4'b0000) begin
      n_fail++;
      $display("FAIL inorder_stall: got %b/%b want 0000/0000",
               ins_out, ins_swap);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy_o !== 16'h0060 || busy !== 16'h0020) begin
      n_fail++;
      $display("FAIL swap_busy: got %h/%h want 0060/0020", busy_o, busy);
    end
  endtask

  task automatic test_intra;
    apply_reset();
    set_slot(0, 4, 1, 2, 1);
    set_slot(1, 9, 0, 4, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0001 || out_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL intra_raw: got %b/%b want 0001/0001", ins_out, out_o);
    end
    clr();
    set_slot(0, 0, 10, 0, 0);
    set_slot(1, 10, 0, 0, 1);
    #1;
    n_chk++;
    if (out_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL intra_war: got %b want 0001", out_o);
    end
    clr();
    set_slot(0, 11, 0, 0, 1);
    set_slot(1, 11, 0, 0, 1);
    #1;
    n_chk++;
    if (out_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL intra_waw: got %b want 0001", out_o);
    end
    clr();
    set_slot(0, 4, 1, 2, 1);
    ins_in_vld[0] = 1'b0;
    set_slot(1, 9, 0, 4, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0010 || swap_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL invalid_slot: got %b/%b want 0010/0000",
               ins_out, swap_o);
    end
    clr();
  endtask

  task automatic test_flush;
    apply_reset();
    for (int i = 0; i < IW; i++) set_slot(i, 4 + i, 0, 0, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL all_grant: got %b want 1111", ins_out);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h00F0) begin
      n_fail++;
      $display("FAIL flush_pre: got %h want 00f0", busy);
    end
    flush_en = 1'b1;
    flush_reg = 16'h0030;
    for (int i = 0; i < IW; i++) set_slot(i, 8 + i, 0, 0, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0000 || out_o !== 4'b0000 || swap_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_out: got %b/%b/%b want 0000", ins_out, out_o,
               swap_o);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h00C0) begin
      n_fail++;
      $display("FAIL flush_busy: got %h want 00c0", busy);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    set_slot(0, 2, 0, 0, 1);
    tick();
    clr();
    set_slot(0, 12, 2, 0, 1);
    #1;
    n_chk++;
    if (ins_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_stall: got %b want 0000", ins_out);
    end
    tick();
    set_wb(3, 2);
    #1;
    n_chk++;
    if (ins_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_release: got %b want 0001", ins_out);
    end
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h1000) begin
      n_fail++;
      $display("FAIL b2b_busy: got %h want 1000", busy);
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    set_slot(0, 7, 0, 0, 1);
    tick();
    clr();
    set_slot(0, 1, 0, 0, 1);
    #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 16'h0000 || ins_out !== 4'b0000 || out_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%b/%b want 0000/0000/0000",
               busy, ins_out, out_o);
    end
    rst = 1'b0;
    tick();
    clr();
    #1;
    n_chk++;
    if (busy !== 16'h0002) begin
      n_fail++;
      $display("FAIL rst_resume: got %h want 0002", busy);
    end
  endtask

  task automatic test_stats;
    apply_reset();
    set_slot(0, 3, 0, 0, 1);
    set_slot(1, 9, 3, 0, 1);
    tick();
    clr();
    #1;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    n_chk++;
    if (stall_cnt !== 32'd1 || issue_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d want 1/1",
               stall_cnt, issue_cnt);
    end
    dut.stall_q = 32'hFFFF_FFFE;
    set_slot(0, 0, 3, 0, 0);
    tick();
    tick();
    clr();
    #1;
    n_chk++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL stats_sat: got %h want ffffffff", stall_cnt);
    end
`else
    n_chk++;
    if (stall_cnt !== 32'd0 || issue_cnt !== 32'd0 ||
        stall_o !== 32'd0 || issue_o !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_off: got %h/%h want 0/0", stall_cnt, issue_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_swap();
    test_intra();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
